// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for fifo_burst_reader.
package fifo_burst_reader_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int STATS_CNT_WIDTH = 32;

endpackage

// File: rtl/fifo_burst_reader.sv
// Frames show-ahead FIFO reads into first/last-marked bursts on a valid/ready stream.
// Define FIFO_BURST_READER_STATS_EN to add the burst_cnt_o / partial_cnt_o statistics outputs.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int BURST_LEN  = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [DATA_WIDTH-1:0]      fifo_data_i,
   input  logic                       fifo_empty_i,
   input  logic [ADDR_WIDTH:0]        fifo_used_words_i,
   output logic                       fifo_rd_o,
   output logic [DATA_WIDTH-1:0]      tdata_o,
   output logic                       tvalid_o,
   input  logic                       tready_i,
   output logic                       tfirst_o,
   output logic                       tlast_o
`ifdef FIFO_BURST_READER_STATS_EN
   ,
   output logic [STATS_CNT_WIDTH-1:0] burst_cnt_o,
   output logic [STATS_CNT_WIDTH-1:0] partial_cnt_o
`endif
);

   localparam int AVW = ADDR_WIDTH + 2;
   localparam int TW  = $clog2(TIMEOUT + 1);

   state_t                r_state;
   state_t                w_stateNext;
   logic [AVW-1:0]        r_burstLen;
   logic [AVW-1:0]        w_burstLenNext;
   logic [AVW-1:0]        r_wordCnt;
   logic [AVW-1:0]        w_wordNext;
   logic [TW-1:0]         r_tmoCnt;
   logic [TW-1:0]         w_tmoNext;
   logic [AVW-1:0]        w_avail;
   logic                  w_free;
   logic                  w_rd;
   logic                  w_partialStart;
   logic [DATA_WIDTH-1:0] r_tdata;
   logic                  r_tvalid;
   logic                  r_tfirst;
   logic                  r_tlast;

   // The word sitting at the FIFO output is not included in the used count.
   assign w_avail = {1'b0, fifo_used_words_i} + {{(AVW-1){1'b0}}, ~fifo_empty_i};
   assign w_free  = ~r_tvalid | tready_i;

   always_comb begin
      w_stateNext    = r_state;
      w_burstLenNext = r_burstLen;
      w_wordNext     = r_wordCnt;
      w_tmoNext      = r_tmoCnt;
      w_rd           = 1'b0;
      w_partialStart = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_avail >= AVW'(BURST_LEN)) begin
               w_stateNext    = BURST;
               w_burstLenNext = AVW'(BURST_LEN);
               w_tmoNext      = '0;
            end else if (w_avail != '0) begin
               if (r_tmoCnt == TW'(TIMEOUT - 1)) begin
                  w_stateNext    = BURST;
                  w_burstLenNext = w_avail;
                  w_tmoNext      = '0;
                  w_partialStart = 1'b1;
               end else begin
                  w_tmoNext = r_tmoCnt + 1'b1;
               end
            end else begin
               w_tmoNext = '0;
            end
         end
         BURST: begin
            w_rd = ~fifo_empty_i & w_free;
            if (w_rd) begin
               if (r_wordCnt == r_burstLen - 1'b1) begin
                  w_wordNext  = '0;
                  w_stateNext = IDLE;
               end else begin
                  w_wordNext = r_wordCnt + 1'b1;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= IDLE;
         r_burstLen <= '0;
         r_wordCnt  <= '0;
         r_tmoCnt   <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_burstLen <= w_burstLenNext;
         r_wordCnt  <= w_wordNext;
         r_tmoCnt   <= w_tmoNext;
      end
   end

   // Single output stage: loads on every pop, otherwise drains when accepted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tfirst <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (w_rd) begin
         r_tdata  <= fifo_data_i;
         r_tvalid <= 1'b1;
         r_tfirst <= (r_wordCnt == '0);
         r_tlast  <= (r_wordCnt == r_burstLen - 1'b1);
      end else if (tready_i) begin
         r_tvalid <= 1'b0;
      end
   end

   assign fifo_rd_o = w_rd;
   assign tdata_o   = r_tdata;
   assign tvalid_o  = r_tvalid;
   assign tfirst_o  = r_tfirst;
   assign tlast_o   = r_tlast;

`ifdef FIFO_BURST_READER_STATS_EN
   logic [STATS_CNT_WIDTH-1:0] r_burstCnt;
   logic [STATS_CNT_WIDTH-1:0] r_partialCnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_burstCnt   <= '0;
         r_partialCnt <= '0;
      end else begin
         if (r_tvalid && tready_i && r_tlast) begin
            r_burstCnt <= r_burstCnt + 1'b1;
         end
         if (w_partialStart) begin
            r_partialCnt <= r_partialCnt + 1'b1;
         end
      end
   end

   assign burst_cnt_o   = r_burstCnt;
   assign partial_cnt_o = r_partialCnt;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised bench for fifo_burst_reader: a queue stands in for the FIFO and a burst-level model predicts the stream.
module tb_fifo_burst_reader;

   localparam int DW  = 8;
   localparam int AW  = 3;
   localparam int BL  = 4;
   localparam int TMO = 16;
   localparam int CAP = 9;

   logic          clk = 1'b0;
   logic          rstN;
   logic [DW-1:0] fifoData;
   logic          fifoEmpty;
   logic [AW:0]   fifoUsed;
   logic          fifoRd;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tfirst;
   logic          tlast;
`ifdef FIFO_BURST_READER_STATS_EN
   logic [31:0]   burstCnt;
   logic [31:0]   partialCnt;
`endif

   fifo_burst_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TMO)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rstN),
      .fifo_data_i      (fifoData),
      .fifo_empty_i     (fifoEmpty),
      .fifo_used_words_i(fifoUsed),
      .fifo_rd_o        (fifoRd),
      .tdata_o          (tdata),
      .tvalid_o         (tvalid),
      .tready_i         (tready),
      .tfirst_o         (tfirst),
      .tlast_o          (tlast)
`ifdef FIFO_BURST_READER_STATS_EN
      ,
      .burst_cnt_o      (burstCnt),
      .partial_cnt_o    (partialCnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fifoQ[$];

   // Reference model: a burst is either waiting to start or has some words left to pop.
   bit            mInBurst;
   int            mLen;
   int            mLeft;
   int            mWait;
   bit            mValid;
   logic [DW-1:0] mData;
   bit            mFirst;
   bit            mLast;
   int            mBurstCnt;
   int            mPartialCnt;
   int            popCount;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic driveFifo();
      fifoEmpty = (fifoQ.size() == 0);
      fifoData  = fifoEmpty ? '0 : fifoQ[0];
      fifoUsed  = fifoEmpty ? '0 : (AW+1)'(fifoQ.size() - 1);
   endtask

   task automatic clearModel();
      mInBurst    = 1'b0;
      mLen        = 0;
      mLeft       = 0;
      mWait       = 0;
      mValid      = 1'b0;
      mData       = '0;
      mFirst      = 1'b0;
      mLast       = 1'b0;
      mBurstCnt   = 0;
      mPartialCnt = 0;
   endtask

   // One clock cycle: push words and set ready, compare at the falling edge, then apply the pop.
   task automatic applyStimulus(input int pushN, input bit ready);
      bit doPop;
      int avail;
      for (int i = 0; i < pushN; i++) begin
         if (fifoQ.size() < CAP) fifoQ.push_back(DW'($urandom));
      end
      tready = ready;
      driveFifo();
      @(negedge clk);
      checkOutput("tvalid", 64'(tvalid), 64'(mValid));
      if (mValid) begin
         checkOutput("tdata", 64'(tdata), 64'(mData));
         checkOutput("tfirst", 64'(tfirst), 64'(mFirst));
         checkOutput("tlast", 64'(tlast), 64'(mLast));
      end
`ifdef FIFO_BURST_READER_STATS_EN
      checkOutput("burst_cnt", 64'(burstCnt), 64'(mBurstCnt));
      checkOutput("partial_cnt", 64'(partialCnt), 64'(mPartialCnt));
`endif
      doPop = mInBurst && (fifoQ.size() > 0) && (!mValid || tready);
      checkOutput("fifo_rd", 64'(fifoRd), 64'(doPop));
      if (mValid && tready && mLast) mBurstCnt++;
      if (mInBurst) begin
         if (doPop) begin
            mValid = 1'b1;
            mData  = fifoQ[0];
            mFirst = (mLeft == mLen);
            mLast  = (mLeft == 1);
            mLeft--;
            if (mLeft == 0) mInBurst = 1'b0;
         end else if (tready) begin
            mValid = 1'b0;
         end
      end else begin
         if (tready) mValid = 1'b0;
         avail = fifoQ.size();
         if (avail >= BL) begin
            mInBurst = 1'b1; mLen = BL; mLeft = BL; mWait = 0;
         end else if (avail > 0) begin
            if (mWait == TMO - 1) begin
               mInBurst = 1'b1; mLen = avail; mLeft = avail; mWait = 0;
               mPartialCnt++;
            end else begin
               mWait++;
            end
         end else begin
            mWait = 0;
         end
      end
      @(posedge clk);
      #1;
      if (doPop) begin
         void'(fifoQ.pop_front());
         popCount++;
      end
      driveFifo();
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge.
   task automatic doReset();
      rstN = 1'b0;
      #1;
      checkOutput("rst_tvalid", 64'(tvalid), 64'd0);
      checkOutput("rst_tfirst", 64'(tfirst), 64'd0);
      checkOutput("rst_tlast", 64'(tlast), 64'd0);
      checkOutput("rst_tdata", 64'(tdata), 64'd0);
      checkOutput("rst_fifo_rd", 64'(fifoRd), 64'd0);
      clearModel();
      @(posedge clk);
      @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   initial begin
      bit pattern[4];
      int startPops;
      pattern  = '{1'b1, 1'b0, 1'b0, 1'b1};
      popCount = 0;
      tready   = 1'b0;
      rstN     = 1'b1;
      driveFifo();
      @(posedge clk);
      #1;
      doReset();

      // Full burst
      applyStimulus(4, 1'b1);
      repeat (9) applyStimulus(0, 1'b1);

      // Partial flush after the idle timeout
      applyStimulus(2, 1'b1);
      repeat (25) applyStimulus(0, 1'b1);

      // Backpressure with ready toggling 1,0,0,1
      applyStimulus(8, 1'b1);
      for (int i = 0; i < 48; i++) applyStimulus(0, pattern[i % 4]);

      // Full FIFO: avail reaches 9
      applyStimulus(9, 1'b1);
      repeat (40) applyStimulus(0, 1'b1);
      checkOutput("fullfifo_drained", 64'(fifoQ.size()), 64'd0);

      // Reset after two words of a burst have been popped
      applyStimulus(4, 1'b1);
      startPops = popCount;
      for (int i = 0; i < 20 && popCount - startPops < 2; i++) applyStimulus(0, 1'b1);
      checkOutput("mid_burst_pops", 64'(popCount - startPops), 64'd2);
      doReset();
      repeat (30) applyStimulus(0, 1'b1);

      // Random traffic and backpressure
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                       $urandom_range(0, 3) != 0);
      end
      repeat (40) applyStimulus(0, 1'b1);
      checkOutput("final_drained", 64'(fifoQ.size()), 64'd0);
      checkOutput("final_idle", 64'(tvalid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
